// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush scheduler for a 5-stage pipeline. It decides every cycle
//   which pipeline registers hold and which take a bubble. The decision uses
//   load-use hazards, taken branches resolved in EX, and a multi-cycle DRAM
//   req/ack handshake in MEM. It also tracks how long a DRAM wait lasts (sticky
//   timeout) and keeps a saturating count of stalled cycles.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   id_rs1/id_rs2, id_re1/2    source registers of the ID instruction and read enables
//   ex_wr, ex_we, ex_is_load   destination, write enable and load flag of the EX instruction
//   ex_br_taken                EX resolved a taken branch/jump
//   mem_req, mem_ack           DRAM access outstanding / completing this cycle
//   *_stop                     hold the named pipeline register (pc, if_id, id_ex, ex_mem)
//   *_flush                    load a bubble into the named pipeline register
//   mem_timeout                sticky: a DRAM wait reached MEM_TIMEOUT cycles
//   stall_cnt                  saturating count of cycles with pc_stop=1
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wr,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             id_ex_stop,
  output logic             ex_mem_stop,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wait counter is at least 8 bits and always wide enough to reach MEM_TIMEOUT.
  localparam int unsigned TmoW  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned WaitW = (TmoW > 8) ? TmoW : 8;

  localparam logic [WaitW-1:0] TmoVal  = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitMax = '1;
  localparam logic [CNT_W-1:0] CntMax  = '1;

  localparam logic [0:0] StRun     = 1'b0;
  localparam logic [0:0] StMemWait = 1'b1;

  logic             freeze;
  logic             hit1;
  logic             hit2;
  logic             lu;

  logic [0:0]       state_d, state_q;
  logic [WaitW-1:0] wait_cnt_d, wait_cnt_q;
  logic             timeout_d, timeout_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign freeze = mem_req & ~mem_ack;
  assign hit1   = id_re1 & (id_rs1 == ex_wr);
  assign hit2   = id_re2 & (id_rs2 == ex_wr);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu     = ex_is_load & ex_we & (ex_wr != 5'd0) & (hit1 | hit2);

  // ---------------------------------------------------------------------------
  // Stop/flush decision, priority freeze > branch > load-use
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_stop      = 1'b0;
    if_id_stop   = 1'b0;
    id_ex_stop   = 1'b0;
    ex_mem_stop  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (freeze) begin
      // Whole front of the pipe holds. MEM/WB takes a bubble so the stalled
      // access does not retire twice. Branch and lu are re-evaluated once the
      // freeze drops, because their inputs are held too.
      pc_stop      = 1'b1;
      if_id_stop   = 1'b1;
      id_ex_stop   = 1'b1;
      ex_mem_stop  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_br_taken) begin
      // The instructions in IF and ID are on the wrong path, so an lu seen in
      // ID is irrelevant.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      // Next cycle the load is in MEM and forwarding covers it; one bubble is enough.
      pc_stop     = 1'b1;
      if_id_stop  = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // DRAM wait tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      StRun: begin
        if (freeze) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (!freeze) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q == TmoVal) begin
            timeout_d = 1'b1;
          end
          if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall counter, saturating
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stop && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
